// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Load/store request/response bundle between the core's memory stage (master)
// and the data memory responder (slave).
//
// Signals
//   req_valid    master->slave  request present
//   req_ready    slave->master  responder can accept a request
//   req_write    master->slave  1 = store, 0 = load
//   req_addr     master->slave  byte address
//   req_wdata    master->slave  store data, right-aligned
//   req_type     master->slave  00 byte, 01 half, 10/11 word
//   req_sign_ext master->slave  loads only: 1 = sign-extend, 0 = zero-extend
//   resp_valid   slave->master  response present
//   resp_ready   master->slave  requester accepts the response
//   resp_rdata   slave->master  load result (0 for stores and faults)
//   resp_err     slave->master  request faulted (misaligned)
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_type;
  logic                  req_sign_ext;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_type, req_sign_ext,
           resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_type, req_sign_ext,
           resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core's load/store port. Accepts one request at
// a time, holds a word-organised RAM with byte/half/word lane handling and
// returns the response LATENCY cycles after acceptance, then holds it until
// the requester takes it.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  data_mem_responder_if.slave (request/response handshake)
//
// Parameters
//   DATA_WIDTH  data/address width (lane logic assumes 32)
//   DEPTH_WORDS RAM depth in 32-bit words, power of two
//   LATENCY     acceptance-to-resp_valid cycles, 1..15
//
// Optional feature
//   MISALIGN_TRAP_EN  defined: misaligned half/word accesses fault (resp_err=1,
//                     no write, rdata 0). Undefined: resp_err is 0 and the
//                     address is force-aligned.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  // Captured request
  logic                  write_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            type_q;
  logic                  sext_q;

  // Response registers
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) state_d = S_RESP;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  // ---------------------------------------------------------------------------
  // Access datapath
  // ---------------------------------------------------------------------------
  // With LATENCY==1 the RESP-entry edge is the acceptance edge itself, so the
  // access uses the live request in IDLE and the captured one afterwards.
  logic                  in_idle;
  logic                  enter_resp;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            acc_type;
  logic                  acc_sext;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane_off;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlanes;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;
  logic                  trap;
  logic                  unused_addr_bits;

  assign in_idle    = (state_q == S_IDLE);
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign acc_write  = in_idle ? bus.req_write    : write_q;
  assign acc_addr   = in_idle ? bus.req_addr     : addr_q;
  assign acc_wdata  = in_idle ? bus.req_wdata    : wdata_q;
  assign acc_type   = in_idle ? bus.req_type     : type_q;
  assign acc_sext   = in_idle ? bus.req_sign_ext : sext_q;

  // Upper address bits alias onto the RAM (wrap modulo DEPTH_WORDS*4).
  assign idx              = acc_addr[IDX_W+1:2];
  assign unused_addr_bits = ^acc_addr[DATA_WIDTH-1:IDX_W+2];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    unique case (acc_type)
      2'b00:   trap = 1'b0;
      2'b01:   trap = acc_addr[0];
      default: trap = (acc_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  // Lane offset is force-aligned; when trapping the access is dropped anyway.
  always_comb begin
    lane_off = 2'b00;
    be       = 4'b1111;
    wlanes   = acc_wdata;
    ext      = shifted;
    unique case (acc_type)
      2'b00: begin
        lane_off = acc_addr[1:0];
        be       = 4'b0001 << acc_addr[1:0];
        wlanes   = {4{acc_wdata[7:0]}};
        ext      = {{(DATA_WIDTH-8){acc_sext & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_off = {acc_addr[1], 1'b0};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{acc_wdata[15:0]}};
        ext      = {{(DATA_WIDTH-16){acc_sext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  assign shifted = mem[idx] >> {lane_off, 3'b000};
  assign rdata_d = (acc_write || trap) ? '0 : ext;
  assign err_d   = trap;

  // Request capture and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= 2'b00;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_idle && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        type_q  <= bus.req_type;
        sext_q  <= bus.req_sign_ext;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // NOTE: the RAM array has no reset; its contents survive rst, and only the
  // write enable is qualified by rst so no store can commit during reset.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && acc_write && !trap) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule
